// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared definitions for the ALU arbiter slice: ALU command codes,
//            FSM state encoding and the op-sanitising helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_arbiter_pkg;

  // ALU command codes, shared with the ALU control decoder.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Op codes above ALU_OR map to ADD, mirroring the ALU control decoder
  // default, so issued command and latency match the datapath behaviour.
  function automatic logic [3:0] legal_cmd(input logic [3:0] op);
    return (op <= ALU_OR) ? op : ALU_ADD;
  endfunction

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Bundles the two requester handshakes, the ALU operand/command
//            bus and the tagged response port of the ALU arbiter.
// Ports    : slave  - arbiter view (requests/alu_result in; ready, ALU
//                     command/operands, response and busy out)
//            master - environment view (mirror of slave)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);

  // Requester 0 (e.g. integer issue path)
  logic              req0_valid;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_ready;

  // Requester 1 (e.g. address-generation path)
  logic              req1_valid;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_ready;

  // ALU datapath
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  // Tagged response and status
  logic              resp_valid;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result,
    output req0_ready, req1_ready,
    output alu_cmd, alu_a, alu_b,
    output resp_valid, resp_id, resp_data, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result,
    input  req0_ready, req1_ready,
    input  alu_cmd, alu_a, alu_b,
    input  resp_valid, resp_id, resp_data, busy
  );

endinterface : alu_arbiter_if
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_rr_arb2
// Purpose  : Two-way round-robin grant. Purely combinational; the history
//            bit (last_grant) is owned and updated by the parent.
// Ports    : valid0, valid1 - request lines
//            last_grant     - id of the most recent accepted requester
//            grant_valid    - at least one request is present
//            grant_id       - requester selected this cycle
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter_rr_arb2 (
  input  wire logic valid0,
  input  wire logic valid1,
  input  wire logic last_grant,
  output logic      grant_valid,
  output logic      grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
    // Contention goes to the requester that was not served last; otherwise
    // the sole requester wins. With no request the id is don't-care (0).
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid1;
    end
  end

endmodule : alu_arbiter_rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one ALU between two requesters. Arbitrates round-robin,
//            drives registered command/operands to the ALU, waits the
//            op-dependent latency, captures alu_result and returns it as a
//            one-cycle pulse tagged with the requester id.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - alu_arbiter_if.slave (requests, ALU bus, response, busy)
// Params   : DATA_W  - operand/result width
//            ALU_LAT - issue-to-result cycles for ADD/SUB/AND/OR (>=1)
//            MUL_LAT - issue-to-result cycles for MUL (>=1)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 4
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  alu_arbiter_if.slave bus
);

  // Counter only needs to hold (max latency - 1).
  localparam int MAX_LAT = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] C_ALU_CNT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] C_MUL_CNT = CNT_W'(MUL_LAT - 1);

  state_t            r_state;
  logic              r_last_grant;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [DATA_W-1:0] r_resp_data;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_fire;
  logic [3:0]        w_sel_op;
  logic [3:0]        w_sel_cmd;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  alu_arbiter_rr_arb2 u_rr_arb2 (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .last_grant  (r_last_grant),
    .grant_valid (w_gnt_valid),
    .grant_id    (w_gnt_id)
  );

  // A grant is only offered in IDLE, so the handshake is simply
  // "IDLE and someone is asking"; the winner sees ready this same cycle.
  assign w_fire         = (r_state == IDLE) && w_gnt_valid;
  assign bus.req0_ready = w_fire && !w_gnt_id;
  assign bus.req1_ready = w_fire &&  w_gnt_id;

  // Request mux for the winning requester.
  always_comb begin
    if (w_gnt_id) begin
      w_sel_op = bus.req1_op;
      w_sel_a  = bus.req1_a;
      w_sel_b  = bus.req1_b;
    end else begin
      w_sel_op = bus.req0_op;
      w_sel_a  = bus.req0_a;
      w_sel_b  = bus.req0_b;
    end
    w_sel_cmd = legal_cmd(w_sel_op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;  // requester 0 wins the first contention
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_cmd        <= ALU_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_cmd        <= w_sel_cmd;
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            // Latency follows the command actually issued, so an illegal
            // op (issued as ADD) gets the single-cycle latency.
            r_cnt        <= (w_sel_cmd == ALU_MUL) ? C_MUL_CNT : C_ALU_CNT;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_resp_data  <= bus.alu_result;
            r_resp_id    <= r_id;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_cmd    = r_cmd;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_data  = r_resp_data;
  assign bus.busy       = (r_state != IDLE);

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter with a response
//            scoreboard and a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AL = 1;
  localparam int ML = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.DATA_W(DW)) bus ();

  alu_arbiter #(.DATA_W(DW), .ALU_LAT(AL), .MUL_LAT(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU
  always_comb begin
    case (bus.alu_cmd)
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_MUL: bus.alu_result = bus.alu_a * bus.alu_b;
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    return (op == ALU_MUL) ? ML : AL;
  endfunction

  task automatic push(input logic id, input logic [31:0] d, input int t, input logic [3:0] op);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.cyc  = t + lat_of(op) + 1;
    sbq.push_back(e);
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL resp_unexpected: actual id=%0d data=%0h required=no response (cycle %0d)",
                 bus.resp_id, bus.resp_data, cyc);
      end else begin
        e = sbq.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(e.id));
        chk("resp_data", 64'(bus.resp_data), 64'(e.data));
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int id, output int t);
    logic ok;
    ok = 1'b0;
    t  = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (((id == 0) ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: actual=no ready for req%0d required=ready within 40 cycles", id);
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: actual=busy stuck high required=idle within 40 cycles");
    end
  endtask

  // Contention table: both requesters valid throughout, results hand-computed.
  logic [3:0]  t4_op  [0:1][0:2] = '{'{ALU_ADD, ALU_SUB, ALU_AND}, '{ALU_MUL, ALU_OR, ALU_MUL}};
  logic [31:0] t4_a   [0:1][0:2] = '{'{32'd100, 32'd50, 32'hF0F0}, '{32'd6, 32'h0F00, 32'h0001_0000}};
  logic [31:0] t4_b   [0:1][0:2] = '{'{32'd23,  32'd8,  32'h0FF0}, '{32'd7, 32'h00F0, 32'h0001_0000}};
  logic [31:0] t4_exp [0:1][0:2] = '{'{32'd123, 32'd42, 32'h00F0}, '{32'd42, 32'h0FF0, 32'h0}};
  logic        t4_order [0:5]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin : stim
    int t;
    int t0;
    int grants;
    int idx [0:1];
    logic g;

    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    rst_n = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_alu_cmd", 64'(bus.alu_cmd), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_id", 64'(bus.resp_id), 64'd0);
    chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);
    step();
    rst_n = 1'b1;

    // ---- req0 ADD 5+7 ----
    step();
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
    wait_ready(0, t);
    chk("add_ready1_low", 64'(bus.req1_ready), 64'd0);
    push(1'b0, 32'd12, t, ALU_ADD);
    step();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    @(negedge clk);
    chk("add_alu_cmd", 64'(bus.alu_cmd), 64'd0);
    chk("add_alu_a", 64'(bus.alu_a), 64'd5);
    chk("add_alu_b", 64'(bus.alu_b), 64'd7);
    chk("add_busy", 64'(bus.busy), 64'd1);
    wait_idle();

    // ---- req1 MUL 3*4, both valid while busy ----
    step();
    set_req(1, 1'b1, ALU_MUL, 32'd3, 32'd4);
    wait_ready(1, t);
    push(1'b1, 32'd12, t, ALU_MUL);
    step();
    set_req(1, 1'b1, ALU_SUB, 32'd99, 32'd1);
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) chk("mul_alu_cmd", 64'(bus.alu_cmd), 64'(ALU_MUL));
      chk("mul_ready0_low", 64'(bus.req0_ready), 64'd0);
      chk("mul_ready1_low", 64'(bus.req1_ready), 64'd0);
    end
    @(negedge clk);
    chk("mul_next_cycle", 64'(cyc), 64'(t + 6));
    chk("mul_next_ready0", 64'(bus.req0_ready), 64'd1);
    chk("mul_next_ready1", 64'(bus.req1_ready), 64'd0);
    push(1'b0, 32'd2, cyc, ALU_ADD);
    step();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    wait_idle();

    // ---- both requesters valid continuously, 6 ops ----
    step();
    idx[0] = 0;
    idx[1] = 0;
    set_req(0, 1'b1, t4_op[0][0], t4_a[0][0], t4_b[0][0]);
    set_req(1, 1'b1, t4_op[1][0], t4_a[1][0], t4_b[1][0]);
    grants = 0;
    for (int c = 0; c < 200 && grants < 6; c++) begin
      @(negedge clk);
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        g = (bus.req1_ready === 1'b1);
        chk("rr_one_hot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
        chk("rr_grant", 64'(g), 64'(t4_order[grants]));
        push(g, t4_exp[g][idx[g]], cyc, t4_op[g][idx[g]]);
        idx[g] = idx[g] + 1;
        grants++;
        step();
        if (idx[g] < 3) set_req(int'(g), 1'b1, t4_op[g][idx[g]], t4_a[g][idx[g]], t4_b[g][idx[g]]);
        else            set_req(int'(g), 1'b0, ALU_ADD, 32'd0, 32'd0);
      end
    end
    chk("rr_grant_count", 64'(grants), 64'd6);
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    wait_idle();

    // ---- illegal op 9 issued as ADD ----
    step();
    set_req(0, 1'b1, 4'd9, 32'd10, 32'd20);
    wait_ready(0, t);
    push(1'b0, 32'd30, t, 4'd9);
    step();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    @(negedge clk);
    chk("ill_alu_cmd", 64'(bus.alu_cmd), 64'd0);
    chk("ill_alu_a", 64'(bus.alu_a), 64'd10);
    wait_idle();

    // ---- req1 drops valid before grant ----
    step();
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
    wait_ready(0, t0);
    push(1'b0, 32'd3, t0, ALU_ADD);
    step();
    set_req(0, 1'b1, ALU_SUB, 32'd9, 32'd4);
    set_req(1, 1'b1, ALU_OR, 32'd7, 32'd8);
    step();
    set_req(1, 1'b0, ALU_OR, 32'd0, 32'd0);
    @(negedge clk);
    chk("drop_ready1_low", 64'(bus.req1_ready), 64'd0);
    wait_ready(0, t);
    chk("drop_grant_cycle", 64'(t), 64'(t0 + 3));
    chk("drop_ready1_at_grant", 64'(bus.req1_ready), 64'd0);
    push(1'b0, 32'd5, t, ALU_SUB);
    step();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    wait_idle();
    step();
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, ALU_OR, 32'h3, 32'hC);
    @(negedge clk);
    chk("drop_after_ready1", 64'(bus.req1_ready), 64'd1);
    chk("drop_after_ready0", 64'(bus.req0_ready), 64'd0);
    push(1'b1, 32'hF, cyc, ALU_OR);
    step();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    wait_idle();

    // ---- reset in the middle of BUSY aborts the op ----
    step();
    set_req(1, 1'b1, ALU_MUL, 32'd5, 32'd5);
    wait_ready(1, t);
    step();
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_alu_cmd", 64'(bus.alu_cmd), 64'd0);
    chk("abort_alu_a", 64'(bus.alu_a), 64'd0);
    step();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    step();
    set_req(0, 1'b1, ALU_ADD, 32'd2, 32'd2);
    set_req(1, 1'b1, ALU_ADD, 32'd3, 32'd3);
    @(negedge clk);
    chk("post_rst_ready0", 64'(bus.req0_ready), 64'd1);
    chk("post_rst_ready1", 64'(bus.req1_ready), 64'd0);
    push(1'b0, 32'd4, cyc, ALU_ADD);
    step();
    set_req(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, 1'b0, ALU_ADD, 32'd0, 32'd0);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_arbiter
`default_nettype wire
